// File: rtl/bus6502_pkg.sv
// Shared types and defaults for the 6502-style bus writer and its request queue.
package bus6502_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_wr_req_t;

  localparam logic [15:0] BUS_IDLE_ADDR_DEFAULT = 16'hFFFC;

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } bus_state_t;

endpackage

// File: rtl/bus6502_req_fifo.sv
// Synchronous request queue; pointers carry one wrap bit so full/empty come from an MSB compare.
module bus6502_req_fifo
  import bus6502_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  bus_wr_req_t push_req_i,
  input  logic        pop_i,
  output bus_wr_req_t pop_req_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  bus_wr_req_t mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_req_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_req_i;
    end
  end

endmodule

// File: rtl/bus6502_writer.sv
// Bus initiator producing Phi2/RW_n/address/data write cycles from a request queue, idle reads otherwise.
// States: STOPPED | Phi2 low, cnt held 0, outputs frozen;  RUN | bus cycles running, stop only at cnt==0
module bus6502_writer
  import bus6502_pkg::*;
#(
  parameter int          PHI_DIV    = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_ADDR  = BUS_IDLE_ADDR_DEFAULT
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        Enable_i,
  input  logic        ReqValid_i,
  output logic        ReqReady_o,
  input  logic [15:0] ReqAddr_i,
  input  logic [7:0]  ReqData_i,
  output logic        Phi2_o,
  output logic        RW_n_o,
  output logic [15:0] AddrPhys_o,
  output logic [7:0]  DataIn_o,
  output logic        Busy_o,
  output logic [15:0] WriteCount_o
);

  localparam int             CW       = $clog2(2 * PHI_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(2 * PHI_DIV - 1);
  localparam logic [CW-1:0]  CNT_HIGH = CW'(PHI_DIV);

  bus_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phi2_q, phi2_d;
  logic          rw_n_q, rw_n_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   wcount_q, wcount_d;

  logic          load, wrap;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  bus_wr_req_t   fifo_head, fifo_in;

  assign ReqReady_o = !fifo_full && !Reset_i;
  assign fifo_push  = ReqValid_i && ReqReady_o;
  assign fifo_in    = '{addr: ReqAddr_i, data: ReqData_i};
  assign fifo_pop   = load && !fifo_empty;

  bus6502_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (Clk_i),
    .rst_i      (Reset_i),
    .push_i     (fifo_push),
    .push_req_i (fifo_in),
    .pop_i      (fifo_pop),
    .pop_req_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      STOPPED: begin
        if (Enable_i) begin
          state_d = RUN;
          cnt_d   = CW'(1);
          load    = 1'b1;
        end
      end
      RUN: begin
        // Enable is only honoured at the cycle boundary so Phi2 pulses are never clipped.
        if (cnt_q == '0 && !Enable_i) begin
          state_d = STOPPED;
        end else begin
          wrap  = (cnt_q == CNT_LAST);
          load  = (cnt_q == '0);
          cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
      end
      default: state_d = STOPPED;
    endcase

    phi2_d = (state_d == RUN) && (cnt_d >= CNT_HIGH);

    rw_n_d = rw_n_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      if (!fifo_empty) begin
        rw_n_d = 1'b0;
        addr_d = fifo_head.addr;
        data_d = fifo_head.data;
      end else begin
        rw_n_d = 1'b1;
        addr_d = IDLE_ADDR;
        data_d = 8'h00;
      end
    end

    wcount_d = wcount_q;
    if (wrap && !rw_n_q) wcount_d = wcount_q + 16'd1;
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q  <= STOPPED;
      cnt_q    <= '0;
      phi2_q   <= 1'b0;
      rw_n_q   <= 1'b1;
      addr_q   <= IDLE_ADDR;
      data_q   <= 8'h00;
      wcount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phi2_q   <= phi2_d;
      rw_n_q   <= rw_n_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wcount_q <= wcount_d;
    end
  end

  assign Phi2_o       = phi2_q;
  assign RW_n_o       = rw_n_q;
  assign AddrPhys_o   = addr_q;
  assign DataIn_o     = data_q;
  assign WriteCount_o = wcount_q;
  assign Busy_o       = !fifo_empty || (!rw_n_q && state_q == RUN);

endmodule
